// File: rtl/imem_stream_loader.sv
// rtl/imem_stream_loader.sv - byte-stream program loader driving the IMEM write port and CPU reset
//
// Receives a frame (16-bit LE word count, 4*N LE data bytes, XOR checksum of the
// data bytes) from a host byte link and writes each assembled word to IMEM.
// The CPU is held in reset until a complete frame has been loaded and verified.
//
// Ports:
//   clk         system clock, all logic on rising edge
//   rst         asynchronous active-low reset
//   load_req    single-cycle pulse: abort/restart a load and re-hold the CPU
//   in_valid    stream byte valid
//   in_data     stream byte
//   in_ready    loader accepts a byte (handshake = in_valid & in_ready)
//   imem_we     IMEM write strobe, one cycle per word
//   imem_addr   IMEM word address (holds when imem_we=0)
//   imem_wdata  IMEM write data (holds when imem_we=0)
//   cpu_rst     active-low CPU reset, 1 only once the load is verified
//   done        load verified, CPU released
//   err         length overflow or checksum mismatch
//   word_cnt    words written in the current load
module imem_stream_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_req,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_rst,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH:0]   word_cnt
);

    localparam int          DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [16:0] DEPTH17 = 17'(DEPTH);

    typedef enum logic [2:0] {
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_CSUM,
        S_RUN,
        S_ERR
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] len;
    logic [23:0] word_buf;
    logic [1:0]  byte_idx;
    logic [7:0]  csum;

    logic        hs;
    logic        last_byte;
    logic        we_nxt;
    logic        ready_nxt;
    logic [16:0] len_new;
    logic [16:0] len_ext;
    logic [16:0] wc_ext;
    logic [16:0] wc_inc;

    assign hs      = in_valid & in_ready;
    assign len_new = {1'b0, in_data, len[7:0]};
    assign len_ext = {1'b0, len};
    assign wc_ext  = 17'(word_cnt);
    assign wc_inc  = wc_ext + 17'd1;

    assign cpu_rst = (state == S_RUN);
    assign done    = (state == S_RUN);
    assign err     = (state == S_ERR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_LEN0;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        last_byte = (state == S_DATA) && hs && (byte_idx == 2'd3);
        we_nxt    = last_byte && !load_req;
        ready_nxt = 1'b0;

        if (load_req) begin
            state_nxt = S_LEN0;
        end else begin
            case (state)
                S_LEN0: if (hs) state_nxt = S_LEN1;
                S_LEN1: begin
                    if (hs) begin
                        if (len_new > DEPTH17)       state_nxt = S_ERR;
                        else if (len_new == 17'd0)   state_nxt = S_CSUM;
                        else                         state_nxt = S_DATA;
                    end
                end
                // word_cnt already counts the word being written, so the last
                // write cycle is the one where it reaches N.
                S_DATA: if (imem_we && (wc_ext == len_ext)) state_nxt = S_CSUM;
                S_CSUM: if (hs) state_nxt = (in_data == csum) ? S_RUN : S_ERR;
                S_RUN:  state_nxt = S_RUN;
                S_ERR:  state_nxt = S_ERR;
                default: state_nxt = S_LEN0;
            endcase
        end

        // Stay ready through intermediate write cycles; close for the final
        // write cycle so the checksum byte is never taken before CSUM.
        case (state_nxt)
            S_LEN0, S_LEN1, S_CSUM: ready_nxt = 1'b1;
            S_DATA:                 ready_nxt = !(we_nxt && (wc_inc == len_ext));
            default:                ready_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            word_cnt   <= '0;
            len        <= '0;
            word_buf   <= '0;
            byte_idx   <= '0;
            csum       <= '0;
        end else begin
            in_ready <= ready_nxt;
            imem_we  <= we_nxt;
            if (load_req) begin
                word_cnt <= '0;
                byte_idx <= '0;
                csum     <= '0;
            end else if (hs) begin
                case (state)
                    S_LEN0: len[7:0]  <= in_data;
                    S_LEN1: len[15:8] <= in_data;
                    S_DATA: begin
                        csum     <= csum ^ in_data;
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: word_buf[7:0]   <= in_data;
                            2'd1: word_buf[15:8]  <= in_data;
                            2'd2: word_buf[23:16] <= in_data;
                            default: begin
                                imem_wdata <= {in_data, word_buf};
                                imem_addr  <= word_cnt[ADDR_WIDTH-1:0];
                                word_cnt   <= word_cnt + 1'b1;
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_stream_loader.sv
// tb/tb_imem_stream_loader.sv - self-checking bench for imem_stream_loader
module tb_imem_stream_loader;

    localparam int AW    = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_req;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_rst;
    logic          done;
    logic          err;
    logic [AW:0]   word_cnt;

    imem_stream_loader #(.ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_req   (load_req),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst    (cpu_rst),
        .done       (done),
        .err        (err),
        .word_cnt   (word_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int n;
        int pct;
        bit bad;
        bit exp_done;
        bit exp_err;
        int exp_words;
    } vec_t;

    int             checks   = 0;
    int             failures = 0;
    logic [7:0]     frame[$];
    logic [AW+31:0] got[$];
    logic [AW+31:0] expw[$];
    logic           we_pend  = 1'b0;
    int             lat_bad  = 0;
    bit             m_done;
    bit             m_err;
    int             m_wc;
    vec_t           vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycle(input logic v, input logic [7:0] d, input logic lr,
                         input logic is4th, output logic hs);
        in_valid = v;
        in_data  = d;
        load_req = lr;
        @(negedge clk);
        if (imem_we !== we_pend) lat_bad++;
        if (imem_we === 1'b1) got.push_back({imem_addr, imem_wdata});
        hs = v && (in_ready === 1'b1) && !lr;
        @(posedge clk);
        #1;
        we_pend = hs && is4th;
    endtask

    task automatic build_frame(input int n, input bit bad);
        logic [7:0] b;
        logic [7:0] cs;
        frame.delete();
        frame.push_back(n[7:0]);
        frame.push_back(n[15:8]);
        if (n > DEPTH) return;
        cs = 8'h00;
        for (int k = 0; k < 4 * n; k++) begin
            b = 8'($urandom);
            cs ^= b;
            frame.push_back(b);
        end
        frame.push_back(bad ? (cs ^ 8'h5A) : cs);
    endtask

    task automatic model_frame();
        int         n;
        logic [7:0] cs;
        logic [31:0] w;
        expw.delete();
        n = int'({frame[1], frame[0]});
        if (n > DEPTH) begin
            m_done = 0;
            m_err  = 1;
            m_wc   = 0;
            return;
        end
        cs = 8'h00;
        for (int i = 0; i < n; i++) begin
            w = {frame[5 + 4*i], frame[4 + 4*i], frame[3 + 4*i], frame[2 + 4*i]};
            cs ^= w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
            expw.push_back({AW'(i), w});
        end
        m_wc   = n;
        m_done = (frame[2 + 4*n] == cs);
        m_err  = !m_done;
    endtask

    task automatic drive(input int pct, input int cnt);
        int   i;
        int   guard;
        int   n;
        int   lim;
        logic hs;
        logic v;
        logic f4;
        i     = 0;
        guard = 0;
        n     = int'({frame[1], frame[0]});
        lim   = (cnt < frame.size()) ? cnt : frame.size();
        while (i < lim && guard < 4000) begin
            v  = ($urandom_range(99) < pct);
            f4 = (i >= 2) && (i < 2 + 4*n) && (((i - 2) % 4) == 3);
            cycle(v, frame[i], 1'b0, f4, hs);
            if (hs) i++;
            guard++;
        end
        chk("bytes_consumed", i, lim);
    endtask

    task automatic pulse_load_req();
        logic hs;
        cycle(1'b1, 8'hEE, 1'b1, 1'b0, hs);
        chk("lr_err", err, 0);
        chk("lr_done", done, 0);
        chk("lr_cpu_rst", cpu_rst, 0);
        chk("lr_word_cnt", word_cnt, 0);
    endtask

    task automatic run_frame(input int pct, input bit e_done, input bit e_err, input int e_words);
        logic hs;
        int   wbad;
        model_frame();
        got.delete();
        lat_bad = 0;
        drive(pct, 1 << 30);
        for (int k = 0; k < 6; k++) cycle(1'($urandom), 8'($urandom), 1'b0, 1'b0, hs);
        chk("write_count", got.size(), e_words);
        wbad = 0;
        if (got.size() == expw.size())
            for (int k = 0; k < got.size(); k++) if (got[k] !== expw[k]) wbad++;
        chk("write_content", wbad, 0);
        chk("done", done, e_done);
        chk("err", err, e_err);
        chk("done_model", done, m_done);
        chk("err_model", err, m_err);
        chk("cpu_rst", cpu_rst, m_done);
        chk("word_cnt", word_cnt, m_wc);
        chk("we_latency", lat_bad, 0);
    endtask

    initial begin
        logic hs;
        vecs[0] = '{n: 3,         pct: 100, bad: 0, exp_done: 1, exp_err: 0, exp_words: 3};
        vecs[1] = '{n: 2,         pct: 100, bad: 1, exp_done: 0, exp_err: 1, exp_words: 2};
        vecs[2] = '{n: 0,         pct: 100, bad: 0, exp_done: 1, exp_err: 0, exp_words: 0};
        vecs[3] = '{n: DEPTH + 1, pct: 100, bad: 0, exp_done: 0, exp_err: 1, exp_words: 0};
        vecs[4] = '{n: 4,         pct: 50,  bad: 0, exp_done: 1, exp_err: 0, exp_words: 4};
        vecs[5] = '{n: DEPTH,     pct: 100, bad: 0, exp_done: 1, exp_err: 0, exp_words: DEPTH};
        vecs[6] = '{n: 5,         pct: 30,  bad: 1, exp_done: 0, exp_err: 1, exp_words: 5};

        rst      = 1'b0;
        load_req = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_imem_we", imem_we, 0);
        chk("rst_imem_addr", imem_addr, 0);
        chk("rst_imem_wdata", imem_wdata, 0);
        chk("rst_cpu_rst", cpu_rst, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_word_cnt", word_cnt, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        frame = '{8'h01, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'hB6};
        run_frame(100, 1'b1, 1'b0, 1);
        if (got.size() > 0) chk("t1_word", got[0], {8'h00, 32'h00A00513});

        for (int t = 0; t < 7; t++) begin
            pulse_load_req();
            build_frame(vecs[t].n, vecs[t].bad);
            run_frame(vecs[t].pct, vecs[t].exp_done, vecs[t].exp_err, vecs[t].exp_words);
        end

        pulse_load_req();
        build_frame(2, 0);
        drive(100, 8);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_imem_we", imem_we, 0);
        chk("mid_rst_word_cnt", word_cnt, 0);
        chk("mid_rst_cpu_rst", cpu_rst, 0);
        @(posedge clk);
        #1;
        rst     = 1'b1;
        we_pend = 1'b0;
        build_frame(2, 0);
        run_frame(100, 1'b1, 1'b0, 2);

        pulse_load_req();
        build_frame(3, 0);
        drive(100, 9);
        pulse_load_req();
        build_frame(2, 0);
        run_frame(70, 1'b1, 1'b0, 2);

        cycle(1'b0, 8'h00, 1'b0, 1'b0, hs);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
